// File: rtl/uinst_fetch_pkg.sv
// poco_upkg: shared types and constants for the microinstruction fetch stage.
//   state_e      - fetch FSM states
//   UWORD_W      - microword width
//   UADDR_W      - micro-address width
//   NOP_WORD_DEF - microword substituted when the ROM never answers
//   tmr_width()  - wait-timer width for a given TIMEOUT
package poco_upkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int UWORD_W = 24;
  localparam int UADDR_W = 8;

  // ALU op 111, every register and RAM enable low
  localparam logic [UWORD_W-1:0] NOP_WORD_DEF = 24'hE00000;

  // Timer counts 0..t-1; t is at least 2, so $clog2 never yields 0
  function automatic int tmr_width(input int t);
    return $clog2(t);
  endfunction

endpackage

// File: rtl/uinst_fetch_if.sv
// uinst_fetch_if: bus bundle around the fetch stage.
//   microsequencer side : upc_addr, upc_valid, upc_ready
//   microcode ROM side  : rom_addr, rom_rd, rom_data, rom_ack
//   datapath side       : uword, uword_valid, uword_ack
//   control / status    : flush, timeout_err
// master = the fetch stage, slave = its surroundings (sequencer, ROM, decode).
interface uinst_fetch_if;
  import poco_upkg::*;

  logic [UADDR_W-1:0] upc_addr;
  logic               upc_valid;
  logic               upc_ready;
  logic [UADDR_W-1:0] rom_addr;
  logic               rom_rd;
  logic [UWORD_W-1:0] rom_data;
  logic               rom_ack;
  logic [UWORD_W-1:0] uword;
  logic               uword_valid;
  logic               uword_ack;
  logic               flush;
  logic               timeout_err;

  modport master (
    input  upc_addr, upc_valid, rom_data, rom_ack, uword_ack, flush,
    output upc_ready, rom_addr, rom_rd, uword, uword_valid, timeout_err
  );

  modport slave (
    output upc_addr, upc_valid, rom_data, rom_ack, uword_ack, flush,
    input  upc_ready, rom_addr, rom_rd, uword, uword_valid, timeout_err
  );

endinterface

// File: rtl/uinst_fetch_timer.sv
// fetch_timer: ROM wait timer, counts up from 0 and flags the last wait cycle.
//   clk      - system clock
//   rst      - async reset, active-low
//   i_clr    - synchronous clear to 0 (wins over i_en)
//   i_en     - count one cycle
//   o_expire - count has reached TIMEOUT-1
module fetch_timer
  import poco_upkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int            TW   = tmr_width(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_cnt;

  assign o_expire = (r_cnt == LAST);

  // Saturates at LAST so a stalled enable can never wrap back to 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uinst_fetch.sv
// uinst_fetch: microinstruction fetch stage between the microsequencer and
// the microcode ROM, with a one-entry last-address cache for self-loops.
//   clk - system clock
//   rst - async reset, active-low
//   bus - uinst_fetch_if.master (sequencer request, ROM strobe/ack,
//         microword valid/ack, flush, sticky timeout_err)
//
//   state | meaning
//   IDLE  | no request outstanding, ready for a new micro-address
//   WAIT  | ROM strobe asserted, waiting for rom_ack or the timeout
//   HOLD  | microword valid, held until the datapath acks it
module uinst_fetch
  import poco_upkg::*;
#(
  parameter int                 TIMEOUT  = 16,
  parameter logic [UWORD_W-1:0] NOP_WORD = NOP_WORD_DEF,
  parameter bit                 HIT_EN   = 1'b1
) (
  input logic            clk,
  input logic            rst,
  uinst_fetch_if.master  bus
);

  state_e r_state;
  state_e w_state_nxt;

  logic [UADDR_W-1:0] r_rom_addr;
  logic               r_rom_rd;
  logic [UWORD_W-1:0] r_uword;
  logic               r_uword_valid;
  logic               r_timeout_err;

  logic               r_cache_vld;
  logic [UADDR_W-1:0] r_cache_addr;
  logic [UWORD_W-1:0] r_cache_word;

  logic w_upc_ready;
  logic w_hit;
  logic w_accept;
  logic w_expire;
  logic w_tmr_clr;
  logic w_tmr_en;

  assign w_hit    = HIT_EN && r_cache_vld && (bus.upc_addr == r_cache_addr);
  // A flush in the same cycle swallows the request
  assign w_accept = bus.upc_valid && w_upc_ready && !bus.flush;

  assign w_tmr_clr = bus.flush || w_accept;
  assign w_tmr_en  = (r_state == WAIT) && !bus.rom_ack;

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) w_state_nxt = w_hit ? HOLD : WAIT;
        end
        WAIT: begin
          if (bus.rom_ack || w_expire) w_state_nxt = HOLD;
        end
        HOLD: begin
          if (w_accept)           w_state_nxt = w_hit ? HOLD : WAIT;
          else if (bus.uword_ack) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_upc_ready = 1'b0;
    case (r_state)
      IDLE:    w_upc_ready = 1'b1;
      HOLD:    w_upc_ready = bus.uword_ack;
      default: w_upc_ready = 1'b0;
    endcase
  end

  // Registered ROM strobe, microword and cache; decisions mirror the FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rom_addr    <= '0;
      r_rom_rd      <= 1'b0;
      r_uword       <= '0;
      r_uword_valid <= 1'b0;
      r_timeout_err <= 1'b0;
      r_cache_vld   <= 1'b0;
      r_cache_addr  <= '0;
      r_cache_word  <= '0;
    end else if (bus.flush) begin
      r_rom_rd      <= 1'b0;
      r_uword_valid <= 1'b0;
      r_cache_vld   <= 1'b0;
    end else if (w_accept) begin
      if (w_hit) begin
        r_uword       <= r_cache_word;
        r_uword_valid <= 1'b1;
      end else begin
        r_rom_addr    <= bus.upc_addr;
        r_rom_rd      <= 1'b1;
        r_uword_valid <= 1'b0;
      end
    end else if (r_state == HOLD && bus.uword_ack) begin
      r_uword_valid <= 1'b0;
    end else if (r_state == WAIT) begin
      // An ack on the expiry edge still delivers real data
      if (bus.rom_ack) begin
        r_uword       <= bus.rom_data;
        r_uword_valid <= 1'b1;
        r_rom_rd      <= 1'b0;
        r_cache_vld   <= 1'b1;
        r_cache_addr  <= r_rom_addr;
        r_cache_word  <= bus.rom_data;
      end else if (w_expire) begin
        r_uword       <= NOP_WORD;
        r_uword_valid <= 1'b1;
        r_rom_rd      <= 1'b0;
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign bus.upc_ready   = w_upc_ready;
  assign bus.rom_addr    = r_rom_addr;
  assign bus.rom_rd      = r_rom_rd;
  assign bus.uword       = r_uword;
  assign bus.uword_valid = r_uword_valid;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uinst_fetch.sv
// tb_uinst_fetch: directed, table-driven bench for uinst_fetch.
// Two instances: dut (cache enabled) and dut_nc (HIT_EN=0), both TIMEOUT=16.
module tb_uinst_fetch;

  logic clk;
  logic rst;

  int n_pass;
  int n_chk;

  uinst_fetch_if bus();
  uinst_fetch_if bus_nc();

  uinst_fetch #(.TIMEOUT(16), .NOP_WORD(24'hE00000), .HIT_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  uinst_fetch #(.TIMEOUT(16), .NOP_WORD(24'hE00000), .HIT_EN(1'b0)) dut_nc (
    .clk (clk),
    .rst (rst),
    .bus (bus_nc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic        v;
    logic [23:0] d;
    logic        k;
    logic        u;
    logic        f;
    logic        e_rdy;
    logic        e_rd;
    logic [7:0]  e_ra;
    logic [23:0] e_uw;
    logic        e_uv;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [7:0] a, input logic v, input logic [23:0] d,
                        input logic k, input logic u, input logic f);
    bus.upc_addr  = a;
    bus.upc_valid = v;
    bus.rom_data  = d;
    bus.rom_ack   = k;
    bus.uword_ack = u;
    bus.flush     = f;
  endtask

  task automatic set_nc(input logic [7:0] a, input logic v, input logic [23:0] d,
                        input logic k, input logic u);
    bus_nc.upc_addr  = a;
    bus_nc.upc_valid = v;
    bus_nc.rom_data  = d;
    bus_nc.rom_ack   = k;
    bus_nc.uword_ack = u;
    bus_nc.flush     = 1'b0;
  endtask

  initial begin
    int cnt;
    n_pass = 0;
    n_chk  = 0;

    //          a      v     d             k     u     f     rdy   rd    ra     uword         uv
    // miss on 05, ROM acks on first WAIT edge, release
    tbl[0]  = '{8'h05, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 24'h000000, 1'b0};
    tbl[1]  = '{8'h05, 1'b0, 24'h123456, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 24'h123456, 1'b1};
    tbl[2]  = '{8'h00, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 24'h123456, 1'b0};
    // repeat 05: hit, valid after one edge, no strobe
    tbl[3]  = '{8'h05, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 24'h123456, 1'b1};
    // HOLD with ack low while the address wanders
    tbl[4]  = '{8'h30, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 24'h123456, 1'b1};
    tbl[5]  = '{8'h31, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 24'h123456, 1'b1};
    tbl[6]  = '{8'h32, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 24'h123456, 1'b1};
    tbl[7]  = '{8'h33, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 24'h123456, 1'b1};
    tbl[8]  = '{8'h34, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 24'h123456, 1'b1};
    // ack with valid: same-edge acceptance of 40 (miss)
    tbl[9]  = '{8'h40, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h40, 24'h123456, 1'b0};
    tbl[10] = '{8'h40, 1'b0, 24'hABCDEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 24'hABCDEF, 1'b1};
    // back-to-back hit on 40 without a bubble
    tbl[11] = '{8'h40, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h40, 24'hABCDEF, 1'b1};
    // cache now holds 40, so 05 misses
    tbl[12] = '{8'h05, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 24'hABCDEF, 1'b0};
    tbl[13] = '{8'h05, 1'b0, 24'h123456, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 24'h123456, 1'b1};
    tbl[14] = '{8'h00, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 24'h123456, 1'b0};
    // late ack in IDLE is ignored
    tbl[15] = '{8'h00, 1'b0, 24'h777777, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 24'h123456, 1'b0};

    rst = 1'b0;
    set_in(8'h00, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
    set_nc(8'h00, 1'b0, 24'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_ready", {31'd0, bus.upc_ready}, 32'd1);
    chk("rst_rom_rd", {31'd0, bus.rom_rd}, 32'd0);
    chk("rst_rom_addr", {24'd0, bus.rom_addr}, 32'd0);
    chk("rst_uword", {8'd0, bus.uword}, 32'd0);
    chk("rst_uvalid", {31'd0, bus.uword_valid}, 32'd0);
    chk("rst_terr", {31'd0, bus.timeout_err}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].a, tbl[i].v, tbl[i].d, tbl[i].k, tbl[i].u, tbl[i].f);
      tick();
      chk($sformatf("row%0d_ready", i), {31'd0, bus.upc_ready}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("row%0d_rom_rd", i), {31'd0, bus.rom_rd}, {31'd0, tbl[i].e_rd});
      chk($sformatf("row%0d_rom_addr", i), {24'd0, bus.rom_addr}, {24'd0, tbl[i].e_ra});
      chk($sformatf("row%0d_uword", i), {8'd0, bus.uword}, {8'd0, tbl[i].e_uw});
      chk($sformatf("row%0d_uvalid", i), {31'd0, bus.uword_valid}, {31'd0, tbl[i].e_uv});
      chk($sformatf("row%0d_terr", i), {31'd0, bus.timeout_err}, 32'd0);
    end

    // Timeout on 10: strobe high for 16 cycles, then NOP word and sticky error
    set_in(8'h10, 1'b1, 24'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("to_rom_addr", {24'd0, bus.rom_addr}, 32'h10);
    set_in(8'h10, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
    cnt = bus.rom_rd ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.rom_rd) break;
      tick();
      if (bus.rom_rd) cnt++;
    end
    chk("to_rd_cycles", cnt, 32'd16);
    chk("to_uword", {8'd0, bus.uword}, 32'hE00000);
    chk("to_uvalid", {31'd0, bus.uword_valid}, 32'd1);
    chk("to_terr", {31'd0, bus.timeout_err}, 32'd1);
    set_in(8'h00, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("to_idle_ready", {31'd0, bus.upc_ready}, 32'd1);
    chk("to_idle_uvalid", {31'd0, bus.uword_valid}, 32'd0);
    // timed-out address was not cached
    set_in(8'h10, 1'b1, 24'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("to_refetch_rd", {31'd0, bus.rom_rd}, 32'd1);
    set_in(8'h10, 1'b0, 24'h0A0A0A, 1'b1, 1'b0, 1'b0);
    tick();
    chk("to_refetch_uword", {8'd0, bus.uword}, 32'h0A0A0A);
    chk("to_refetch_terr", {31'd0, bus.timeout_err}, 32'd1);
    set_in(8'h00, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
    tick();

    // Ack on the very edge the timer expires: the ack wins
    set_in(8'h11, 1'b1, 24'h0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(8'h11, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk("race_rd_still", {31'd0, bus.rom_rd}, 32'd1);
    set_in(8'h11, 1'b0, 24'hBBBBBB, 1'b1, 1'b0, 1'b0);
    tick();
    chk("race_uword", {8'd0, bus.uword}, 32'hBBBBBB);
    chk("race_uvalid", {31'd0, bus.uword_valid}, 32'd1);
    chk("race_rd", {31'd0, bus.rom_rd}, 32'd0);
    set_in(8'h00, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
    tick();

    // Prime the cache with 05, then flush mid-WAIT for 20
    set_in(8'h05, 1'b1, 24'h0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(8'h05, 1'b0, 24'h123456, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(8'h00, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(8'h20, 1'b1, 24'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fl_wait_rd", {31'd0, bus.rom_rd}, 32'd1);
    chk("fl_wait_addr", {24'd0, bus.rom_addr}, 32'h20);
    set_in(8'h20, 1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("fl_rd", {31'd0, bus.rom_rd}, 32'd0);
    chk("fl_ready", {31'd0, bus.upc_ready}, 32'd1);
    chk("fl_uvalid", {31'd0, bus.uword_valid}, 32'd0);
    chk("fl_terr", {31'd0, bus.timeout_err}, 32'd1);
    set_in(8'h00, 1'b0, 24'h555555, 1'b1, 1'b0, 1'b0);
    tick();
    chk("fl_late_uvalid", {31'd0, bus.uword_valid}, 32'd0);
    chk("fl_late_uword", {8'd0, bus.uword}, 32'h123456);
    chk("fl_late_rd", {31'd0, bus.rom_rd}, 32'd0);
    // request alongside flush is dropped
    set_in(8'h05, 1'b1, 24'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("fl_req_rd", {31'd0, bus.rom_rd}, 32'd0);
    chk("fl_req_uvalid", {31'd0, bus.uword_valid}, 32'd0);
    // cache was invalidated, so 05 misses
    set_in(8'h05, 1'b1, 24'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fl_miss_rd", {31'd0, bus.rom_rd}, 32'd1);
    chk("fl_miss_addr", {24'd0, bus.rom_addr}, 32'h05);
    chk("fl_miss_uvalid", {31'd0, bus.uword_valid}, 32'd0);

    // Async reset mid-WAIT, between clock edges
    set_in(8'h05, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_rd", {31'd0, bus.rom_rd}, 32'd0);
    chk("arst_uvalid", {31'd0, bus.uword_valid}, 32'd0);
    chk("arst_terr", {31'd0, bus.timeout_err}, 32'd0);
    chk("arst_ready", {31'd0, bus.upc_ready}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_rel_ready", {31'd0, bus.upc_ready}, 32'd1);
    tick();

    // HIT_EN=0: the repeated address still goes to the ROM
    set_nc(8'h05, 1'b1, 24'h0, 1'b0, 1'b0);
    tick();
    chk("nc_first_rd", {31'd0, bus_nc.rom_rd}, 32'd1);
    set_nc(8'h05, 1'b0, 24'h123456, 1'b1, 1'b0);
    tick();
    chk("nc_first_uword", {8'd0, bus_nc.uword}, 32'h123456);
    set_nc(8'h00, 1'b0, 24'h0, 1'b0, 1'b1);
    tick();
    set_nc(8'h05, 1'b1, 24'h0, 1'b0, 1'b0);
    tick();
    chk("nc_repeat_rd", {31'd0, bus_nc.rom_rd}, 32'd1);
    chk("nc_repeat_uvalid", {31'd0, bus_nc.uword_valid}, 32'd0);
    set_nc(8'h05, 1'b0, 24'h654321, 1'b1, 1'b0);
    tick();
    chk("nc_repeat_uword", {8'd0, bus_nc.uword}, 32'h654321);
    chk("nc_repeat_uvalid2", {31'd0, bus_nc.uword_valid}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uinst_fetch.md
Name: uinst_fetch

Overview:
- Microinstruction fetch stage between the microsequencer (w_uPC address output) and the external microcode ROM.
- Accepts a micro-address, runs a strobe/acknowledge read cycle on the ROM with a timeout, and latches the 24-bit microword.
- Presents the latched microword to the datapath decode with a valid/ack handshake.
- Keeps a one-entry last-address cache so a repeated micro-address (self-loop) skips the ROM.

Parameters:
- TIMEOUT, 16: ROM wait cycles before abort; legal range 2..255.
- NOP_WORD, 24'hE00000: substituted microword on timeout. ALU op 111, no register or RAM enables.
- HIT_EN, 1: 1 enables the last-address cache; 0 makes every fetch go to ROM.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-low.
- upc_addr  in  8  requested micro-address.
- upc_valid  in  1  request valid.
- upc_ready  out  1  fetch stage can accept a request this cycle.
- rom_addr  out  8  ROM address, registered.
- rom_rd  out  1  ROM read strobe, registered, active-high.
- rom_data  in  24  ROM read data.
- rom_ack  in  1  ROM data valid; sampled only in WAIT.
- uword  out  24  latched microword.
- uword_valid  out  1  uword valid for the datapath.
- uword_ack  in  1  datapath consumed uword.
- flush  in  1  synchronous abort and cache invalidate.
- timeout_err  out  1  sticky; set on any timeout.

Behaviour:
- Reset (rst=0, async) gives:
  - state IDLE, rom_addr=0, rom_rd=0, uword=0, uword_valid=0, timeout_err=0.
  - cache invalid, timer=0.
  - upc_ready=1 immediately, since it decodes from IDLE.
- States: IDLE, WAIT, HOLD. upc_ready = (state==IDLE) | (state==HOLD & uword_ack).
- Acceptance: a request is accepted at the edge where upc_valid & upc_ready.
  - Hit (HIT_EN, cache valid, upc_addr==cached addr): go to HOLD, uword<=cached word, uword_valid=1 after the same edge. Latency 1. rom_rd stays 0.
  - Miss: rom_addr<=upc_addr, rom_rd<=1, timer<=0, go to WAIT.
- WAIT:
  - rom_addr and rom_rd are held stable.
  - rom_ack=1 at an edge: uword<=rom_data, cache<={upc addr, rom_data, valid}, rom_rd<=0, go to HOLD. Minimum miss latency is 2 edges from acceptance.
  - No ack: timer increments.
  - Timeout: when timer==TIMEOUT-1 at an edge with rom_ack=0, then uword<=NOP_WORD, timeout_err<=1, rom_rd<=0, go to HOLD. The cache is not updated.
  - If rom_ack=1 on the same edge the timer expires, the ack wins.
- HOLD:
  - uword_valid=1 and uword is stable until uword_ack.
  - uword_ack & !upc_valid: go to IDLE, uword_valid<=0. uword keeps its value.
  - uword_ack & upc_valid: back-to-back acceptance of the next request, as from IDLE. There is no bubble on a hit.
- flush=1 at an edge (priority over everything except reset):
  - go to IDLE, rom_rd<=0, uword_valid<=0, cache invalid, timer=0.
  - A request presented in the same cycle is not accepted.
  - timeout_err is unchanged; only rst clears it.
- A late rom_ack outside WAIT is ignored.
- rom_data is don't-care outside the ack edge.
- Reset asserted mid-WAIT drops rom_rd asynchronously.

Decomposition:
- Package poco_upkg:
  - state enum {IDLE, WAIT, HOLD}
  - UWORD_W=24, UADDR_W=8
  - default NOP_WORD constant
  - timer width derived from TIMEOUT
- One natural sub-module: fetch_timer.
  - Clear, enable and expire signals; parameterised by TIMEOUT.
  - Async active-low reset.
- The cache registers stay inline.

Test Plan:
1. Reset release, upc_addr=8'h05 valid, ROM acks on the first WAIT edge with 24'h123456:
   - rom_rd high exactly 1 cycle with rom_addr=05.
   - uword=24'h123456, uword_valid 2 edges after acceptance.
2. Repeat request 8'h05 after ack:
   - rom_rd stays 0, uword=24'h123456 valid 1 edge after acceptance (hit).
   - With HIT_EN=0 the same stimulus gives a full ROM cycle.
3. Request 8'h10, rom_ack never asserted, TIMEOUT=16:
   - rom_rd high 16 cycles, then uword=24'hE00000, uword_valid=1, timeout_err=1.
   - A following request to 8'h10 misses, i.e. a ROM cycle occurs.
4. Hold uword_ack low 5 cycles in HOLD while the core changes upc_addr:
   - uword and uword_valid are stable, upc_ready=0.
   - Then ack together with upc_valid gives same-edge acceptance of the new address.
5. flush during WAIT for 8'h20 (ack arriving 1 cycle later):
   - rom_rd drops, state IDLE, uword_valid stays 0, the late ack is ignored.
   - The next request to 8'h05 misses.
6. rst pulled low asynchronously mid-WAIT (no clock edge):
   - rom_rd=0, uword_valid=0, timeout_err=0 immediately.
   - upc_ready=1 after release.
